uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//  Serial receive stage of the UART. Sits directly downstream of the baud clock generator and consumes its 16x
//  oversampling tick (baud_clock). Synchronises the asynchronous rx line, detects and validates start bits, and
//  majority-votes each bit. Assembles 7/8-bit frames with optional parity, then presents the byte in a holding
//  register with ready, error and overflow flags for the APB register block.
// PARAMETERS
//  SYNC_STAGES  2  number of rx synchroniser flops (legal range >= 2)
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  reset_n       in   1  synchronous reset, active-low
//  baud_clock    in   1  16x oversample tick from clock generator, 1-clk pulse
//  rx            in   1  asynchronous serial input, idle high
//  bit8          in   1  1: 8 data bits, 0: 7 data bits
//  parity_en     in   1  1: parity bit expected after data
//  odd_n_even    in   1  1: odd parity, 0: even parity
//  read_rx_byte  in   1  1-clk strobe: host consumed rx_data
//  rx_data       out  8  received byte, LSB first on line; bit7=0 in 7-bit mode
//  rx_ready      out  1  rx_data holds an unread byte
//  parity_err    out  1  parity mismatch on the byte in rx_data
//  framing_err   out  1  stop bit sampled low on the byte in rx_data
//  overflow      out  1  an unread byte was overwritten
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge clk): state=IDLE, counters 0, synchroniser flops=1, rx_data=0; rx_ready,
//    parity_err, framing_err and overflow all 0. Reset mid-frame abandons the frame with no flag update.
//  - rx_s = rx delayed through SYNC_STAGES flops. All sampling below happens only on cycles with baud_clock=1.
//  - smp_cnt: 4-bit tick counter, wraps 15->0. Bit value = majority of rx_s at smp_cnt=7,8,9.
//  - FSM states:
//    IDLE: on tick with rx_s=0 -> START with smp_cnt=1. Latch bit8/parity_en/odd_n_even for the frame here;
//      changes to these inputs mid-frame are ignored.
//    START: at smp_cnt=9, if majority=1 -> IDLE (glitch reject, no flags). Else continue; at smp_cnt=15 -> DATA,
//      with smp_cnt=0 and bit_cnt=0.
//    DATA: at smp_cnt=9, shift the majority bit into a shift register (LSB first). At smp_cnt=15, bit_cnt++;
//      after the last bit (7 or 8 bits) go to PARITY if parity_en, else STOP.
//    PARITY: at smp_cnt=9 capture pbit. At smp_cnt=15 -> STOP.
//    STOP: at smp_cnt=9 evaluate stop=majority, load the output and go to IDLE immediately. This makes the
//      start of the next frame detectable during the second half of the stop bit.
//  - Load (1 clk after the stop smp_cnt=9 tick), all outputs updated in the same cycle:
//    - rx_data = shifted byte, or {1'b0, 7 bits} in 7-bit mode.
//    - rx_ready = 1.
//    - framing_err = ~stop.
//    - parity_err = parity_en & ((^data ^ pbit) != odd_n_even).
//    - overflow is set if rx_ready was already 1 and read_rx_byte=0 in the load cycle. The new byte overwrites
//      the old one. overflow stays 1 until read.
//    - Frames with framing or parity errors are still loaded.
//  - read_rx_byte=1 (no load in the same cycle): next cycle rx_ready, parity_err, framing_err and overflow
//    are 0; rx_data is unchanged.
//  - Load and read in the same cycle: the load wins (flags take the new frame values) and overflow is not set.
//  - read_rx_byte with rx_ready=0: no effect.
//  - A permanently low line (break) is received as 0x00 with framing_err=1, then restarts each frame.
//  - baud_clock stuck low: the FSM holds its state indefinitely with no timeout.
// TESTING
//  T1 8N1, baud_clock every clk, rx frame 0xA5 -> rx_ready=1, rx_data=0xA5, all error flags 0.
//  T2 rx low for 4 ticks then high -> FSM returns to IDLE at smp_cnt=9, rx_ready stays 0.
//  T3 7-bit, even parity, data 0x41, parity bit driven 1 (wrong) -> rx_data=0x41, parity_err=1.
//  T4 8N1 0x5A with stop bit driven 0 -> rx_data=0x5A, framing_err=1, rx_ready=1.
//  T5 frames 0x11 then 0x22, no read -> rx_data=0x22, overflow=1. Then pulse read_rx_byte -> next clk all
//     flags 0.
//  T6 reset_n=0 for 1 clk during data bit 3 -> next clk all outputs 0, FSM IDLE; the following frame 0x3C is
//     received correctly.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: synchronises rx, validates start bits, 3-point majority votes each bit at 16x
// oversampling, assembles 7/8-bit frames with optional parity and holds the byte with ready/error/overflow flags.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             smp_cnt_q, smp_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   s7_q, s7_d, s8_q, s8_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   pbit_q, pbit_d, stop_q, stop_d, load_q, load_d;
  logic                   bit8_q, bit8_d, par_en_q, par_en_d, odd_q, odd_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_ready_q, rx_ready_d, perr_q, perr_d;
  logic                   ferr_q, ferr_d, ovf_q, ovf_d;
  logic                   rx_s, maj;
  logic [7:0]             frame_data;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  // In 7-bit mode only seven shifts happen, so the byte sits in the top seven bits.
  assign frame_data = bit8_q ? shreg_q : {1'b0, shreg_q[7:1]};

  always_comb begin
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shreg_d    = shreg_q;
    pbit_d     = pbit_q;
    stop_d     = stop_q;
    load_d     = 1'b0;
    bit8_d     = bit8_q;
    par_en_d   = par_en_q;
    odd_d      = odd_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = rx_ready_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovf_d      = ovf_q;

    if (baud_clock) begin
      if (state_q != IDLE) begin
        smp_cnt_d = smp_cnt_q + 4'd1;
        if (smp_cnt_q == 4'd7) s7_d = rx_s;
        if (smp_cnt_q == 4'd8) s8_d = rx_s;
      end
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d   = START;
            smp_cnt_d = 4'd1;
            bit8_d    = bit8;
            par_en_d  = parity_en;
            odd_d     = odd_n_even;
          end
        end
        START: begin
          if (smp_cnt_q == 4'd9 && maj) begin
            state_d   = IDLE;
            smp_cnt_d = 4'd0;
          end else if (smp_cnt_q == 4'd15) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          if (smp_cnt_q == 4'd9) shreg_d = {maj, shreg_q[7:1]};
          if (smp_cnt_q == 4'd15) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == (bit8_q ? 3'd7 : 3'd6)) state_d = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (smp_cnt_q == 4'd9) pbit_d = maj;
          if (smp_cnt_q == 4'd15) state_d = STOP;
        end
        STOP: begin
          // Leaving mid-bit lets a start edge in the second half of the stop bit be seen.
          if (smp_cnt_q == 4'd9) begin
            stop_d    = maj;
            load_d    = 1'b1;
            state_d   = IDLE;
            smp_cnt_d = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load_q) begin
      rx_data_d  = frame_data;
      rx_ready_d = 1'b1;
      ferr_d     = ~stop_q;
      perr_d     = par_en_q & ((^frame_data ^ pbit_q) != odd_q);
      ovf_d      = rx_ready_q & ~read_rx_byte;
    end else if (read_rx_byte && rx_ready_q) begin
      rx_ready_d = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync_q     <= {SYNC_STAGES{1'b1}};
      smp_cnt_q  <= 4'd0;
      bit_cnt_q  <= 3'd0;
      s7_q       <= 1'b0;
      s8_q       <= 1'b0;
      shreg_q    <= 8'd0;
      pbit_q     <= 1'b0;
      stop_q     <= 1'b0;
      load_q     <= 1'b0;
      bit8_q     <= 1'b0;
      par_en_q   <= 1'b0;
      odd_q      <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_ready_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      smp_cnt_q  <= smp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      shreg_q    <= shreg_d;
      pbit_q     <= pbit_d;
      stop_q     <= stop_d;
      load_q     <= load_d;
      bit8_q     <= bit8_d;
      par_en_q   <= par_en_d;
      odd_q      <= odd_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_ready    = rx_ready_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed frame table, hand-written corner sequences, randomized frames vs a frame-level model.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_clock = 1'b0;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       read_rx_byte = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, parity_err, framing_err, overflow;

  int checks = 0;
  int errors = 0;
  int div = 1;

  uart_rx_sampler #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .rx_data(rx_data), .rx_ready(rx_ready), .parity_err(parity_err),
    .framing_err(framing_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt >= div) begin
        cnt = 0;
        baud_clock = 1'b1;
      end else begin
        baud_clock = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic       b8, pe, odd, pbit, stp, rd;
    logic [7:0] e_d;
    logic       e_pe, e_fe, e_rdy, e_ov;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check5(string tag, logic [7:0] ed, logic ep, logic ef, logic er, logic eo);
    @(negedge clk);
    chk({tag, ".data"}, int'(rx_data), int'(ed));
    chk({tag, ".parity_err"}, int'(parity_err), int'(ep));
    chk({tag, ".framing_err"}, int'(framing_err), int'(ef));
    chk({tag, ".rx_ready"}, int'(rx_ready), int'(er));
    chk({tag, ".overflow"}, int'(overflow), int'(eo));
  endtask

  task automatic wait_ticks(int n);
    int c = 0;
    int guard = 0;
    while (c < n) begin
      @(posedge clk);
      if (baud_clock) c++;
      guard++;
      if (guard > n * 8 + 100) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout: got %0d ticks expected %0d", c, n);
        break;
      end
    end
    #1;
  endtask

  task automatic pulse_read();
    @(posedge clk);
    #1 read_rx_byte = 1'b1;
    @(posedge clk);
    #1 read_rx_byte = 1'b0;
  endtask

  task automatic send_frame(logic [7:0] d, logic b8, logic pe, logic odd, logic pbit, logic stp, logic scramble);
    bit8 = b8;
    parity_en = pe;
    odd_n_even = odd;
    rx = 1'b0;
    wait_ticks(8);
    if (scramble) begin
      bit8 = 1'($urandom);
      parity_en = 1'($urandom);
      odd_n_even = 1'($urandom);
    end
    wait_ticks(8);
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (pe) begin
      rx = pbit;
      wait_ticks(16);
    end
    rx = stp;
    wait_ticks(16);
    rx = 1'b1;
  endtask

  task automatic run_vec(string tag, vec_t v);
    if (v.rd) begin
      pulse_read();
      wait_ticks(2);
    end
    send_frame(v.d, v.b8, v.pe, v.odd, v.pbit, v.stp, 1'b0);
    wait_ticks(20);
    check5(tag, v.e_d, v.e_pe, v.e_fe, v.e_rdy, v.e_ov);
  endtask

  initial begin
    logic [7:0] d, dm, m_data;
    logic       b8, pe, odd, flip, stp, pb, m_ready, m_ovf;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check5("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Short low pulse must be rejected as a glitch.
    wait_ticks(4);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(30);
    check5("glitch", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    pulse_read();
    check5("read_clear", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_read();
    check5("read_idle", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);

    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ticks(20);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ticks(20);
    check5("ovf_again", 8'h44, 1'b0, 1'b0, 1'b1, 1'b1);

    // Read lands exactly in the load cycle: stop bit starts at edge Ps, majority at
    // Ps+12 (2 sync flops + detect tick), output load one clock later at Ps+13.
    bit8 = 1'b1;
    parity_en = 1'b0;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d_const77(i);
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(12);
    read_rx_byte = 1'b1;
    wait_ticks(1);
    read_rx_byte = 1'b0;
    wait_ticks(20);
    check5("load_read", 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during data bit 3 of 0x3C.
    rx = 1'b0;
    wait_ticks(16);
    d = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[3];
    wait_ticks(8);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    rx = 1'b1;
    check5("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ticks(30);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ticks(20);
    check5("after_reset", 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);

    m_ready = 1'b1;
    m_ovf = 1'b0;
    m_data = 8'h3C;
    for (int n = 0; n < 40; n++) begin
      div = $urandom_range(1, 3);
      wait_ticks(3);
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        m_ready = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        chk($sformatf("rnd%0d.read_ready", n), int'(rx_ready), int'(m_ready));
        chk($sformatf("rnd%0d.read_data", n), int'(rx_data), int'(m_data));
      end
      d = 8'($urandom);
      b8 = 1'($urandom);
      pe = 1'($urandom);
      odd = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      dm = b8 ? d : {1'b0, d[6:0]};
      pb = (^dm) ^ odd ^ flip;
      send_frame(d, b8, pe, odd, pb, stp, 1'b1);
      wait_ticks(20);
      m_ovf = m_ready;
      m_ready = 1'b1;
      m_data = dm;
      check5($sformatf("rnd%0d", n), m_data, pe & flip, ~stp, m_ready, m_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic d_const77(int i);
    logic [7:0] v;
    v = 8'h77;
    return v[i];
  endfunction

endmodule
